// File: rtl/bcid_pkg.sv
// Shared BCID definitions for the transmit counter and the receive-side lock checker.
package bcid_pkg;

    localparam int unsigned BCID_WIDTH  = 12;
    localparam int unsigned STATE_WIDTH = 2;

    localparam logic [BCID_WIDTH-1:0] MAX_BCID_NUMBER = 12'd3563;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } bcidState_t;

    // Wrap incrementer: the BCID after x, returning to 0 past the last valid bunch.
    function automatic logic [BCID_WIDTH-1:0] bcid_next(
        input logic [BCID_WIDTH-1:0] x,
        input logic [BCID_WIDTH-1:0] maxBcid = MAX_BCID_NUMBER
    );
        return (x == maxBcid) ? '0 : x + BCID_WIDTH'(1);
    endfunction

endpackage

// File: rtl/bcid_track_counter.sv
// Loadable free-running BCID predictor; a load seeds it with the BCID following loadValueTMR.
module bcid_track_counter
    import bcid_pkg::*;
#(
    parameter logic [BCID_WIDTH-1:0] MAX_BCID = MAX_BCID_NUMBER
) (
    input  logic                  clkTMR,
    input  logic                  resetTMR,
    input  logic                  enTMR,
    input  logic                  loadTMR,
    input  logic [BCID_WIDTH-1:0] loadValueTMR,
    output logic [BCID_WIDTH-1:0] countTMR
);

    // Advance every enabled cycle; a load replaces the advance.
    always_ff @(posedge clkTMR or negedge resetTMR) begin
        if (!resetTMR) begin
            countTMR <= '0;
        end else if (enTMR) begin
            if (loadTMR) begin
                countTMR <= bcid_next(loadValueTMR, MAX_BCID);
            end else begin
                countTMR <= bcid_next(countTMR, MAX_BCID);
            end
        end
    end

endmodule

// File: rtl/bcid_lock_checker.sv
// Receive-side BCID checker: acquires lock to the incoming BCID stream and counts mismatches.
module bcid_lock_checker
    import bcid_pkg::*;
#(
    parameter logic [BCID_WIDTH-1:0] MAX_BCID     = MAX_BCID_NUMBER,
    parameter int unsigned           LOCK_COUNT   = 4,
    parameter int unsigned           UNLOCK_COUNT = 3,
    parameter int unsigned           ERRCNT_WIDTH = 16
) (
    input  logic                    clkTMR,
    input  logic                    resetTMR,
    input  logic                    enTMR,
    input  logic                    bcidValidTMR,
    input  logic [BCID_WIDTH-1:0]   bcidInTMR,
    input  logic                    clrErrTMR,
    output logic [BCID_WIDTH-1:0]   expectedTMR,
    output logic                    lockedTMR,
    output logic [STATE_WIDTH-1:0]  stateTMR,
    output logic                    mismatchTMR,
    output logic [ERRCNT_WIDTH-1:0] errCountTMR
);

    localparam int unsigned CNT_WIDTH = 4;

    bcidState_t           state;
    logic [CNT_WIDTH-1:0] matchCnt;
    logic [CNT_WIDTH-1:0] missCnt;
    logic [CNT_WIDTH-1:0] matchNext;
    logic [CNT_WIDTH-1:0] missNext;
    logic                 sampleEn;
    logic                 inRange;
    logic                 isMatch;
    logic                 reload;

    // Sample qualification; out-of-range values can never equal the predictor.
    assign sampleEn  = enTMR & bcidValidTMR;
    assign inRange   = (bcidInTMR <= MAX_BCID);
    assign isMatch   = inRange && (bcidInTMR == expectedTMR);
    assign matchNext = matchCnt + CNT_WIDTH'(1);
    assign missNext  = missCnt + CNT_WIDTH'(1);
    assign reload    = sampleEn && inRange &&
                       ((state == ST_SEARCH) || ((state == ST_VERIFY) && !isMatch));
    assign stateTMR  = state;

    bcid_track_counter #(
        .MAX_BCID (MAX_BCID)
    ) uPredictor (
        .clkTMR       (clkTMR),
        .resetTMR     (resetTMR),
        .enTMR        (enTMR),
        .loadTMR      (reload),
        .loadValueTMR (bcidInTMR),
        .countTMR     (expectedTMR)
    );

    // Lock FSM with match/miss counters and the mismatch pulse.
    always_ff @(posedge clkTMR or negedge resetTMR) begin
        if (!resetTMR) begin
            state       <= ST_SEARCH;
            lockedTMR   <= 1'b0;
            mismatchTMR <= 1'b0;
            matchCnt    <= '0;
            missCnt     <= '0;
        end else begin
            mismatchTMR <= 1'b0;
            if (sampleEn) begin
                case (state)
                    ST_SEARCH: begin
                        if (inRange) begin
                            state    <= ST_VERIFY;
                            matchCnt <= '0;
                        end
                    end
                    ST_VERIFY: begin
                        if (isMatch) begin
                            if (matchNext == CNT_WIDTH'(LOCK_COUNT)) begin
                                state     <= ST_LOCKED;
                                lockedTMR <= 1'b1;
                                matchCnt  <= '0;
                                missCnt   <= '0;
                            end else begin
                                matchCnt <= matchNext;
                            end
                        end else if (inRange) begin
                            mismatchTMR <= 1'b1;
                            matchCnt    <= '0;
                        end else begin
                            mismatchTMR <= 1'b1;
                            state       <= ST_SEARCH;
                        end
                    end
                    ST_LOCKED: begin
                        if (isMatch) begin
                            missCnt <= '0;
                        end else begin
                            mismatchTMR <= 1'b1;
                            if (missNext == CNT_WIDTH'(UNLOCK_COUNT)) begin
                                state     <= ST_SEARCH;
                                lockedTMR <= 1'b0;
                                missCnt   <= '0;
                            end else begin
                                missCnt <= missNext;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_SEARCH;
                        lockedTMR <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; clear wins and works regardless of enable.
    always_ff @(posedge clkTMR or negedge resetTMR) begin
        if (!resetTMR) begin
            errCountTMR <= '0;
        end else if (clrErrTMR) begin
            errCountTMR <= '0;
        end else if (sampleEn && (state == ST_LOCKED) && !isMatch && (errCountTMR != '1)) begin
            errCountTMR <= errCountTMR + ERRCNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_bcid_lock_checker.sv
// Scoreboard bench for bcid_lock_checker: driver queues expectations, monitor compares each cycle.
module tb_bcid_lock_checker;

    localparam logic [1:0] S = 2'd0;
    localparam logic [1:0] V = 2'd1;
    localparam logic [1:0] L = 2'd2;

    logic        clkTMR;
    logic        resetTMR;
    logic        enTMR;
    logic        bcidValidTMR;
    logic [11:0] bcidInTMR;
    logic        clrErrTMR;
    logic [11:0] expectedTMR;
    logic        lockedTMR;
    logic [1:0]  stateTMR;
    logic        mismatchTMR;
    logic [3:0]  errCountTMR;

    typedef struct {
        logic [1:0]  st;
        logic        mis;
        logic [3:0]  err;
        logic [11:0] ex;
        int          tag;
    } expect_t;

    expect_t sb[$];
    expect_t monE;
    int      checks = 0;
    int      errors = 0;
    int      stepNo = 0;

    bcid_lock_checker #(
        .MAX_BCID     (12'd3563),
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (3),
        .ERRCNT_WIDTH (4)
    ) dut (
        .clkTMR       (clkTMR),
        .resetTMR     (resetTMR),
        .enTMR        (enTMR),
        .bcidValidTMR (bcidValidTMR),
        .bcidInTMR    (bcidInTMR),
        .clrErrTMR    (clrErrTMR),
        .expectedTMR  (expectedTMR),
        .lockedTMR    (lockedTMR),
        .stateTMR     (stateTMR),
        .mismatchTMR  (mismatchTMR),
        .errCountTMR  (errCountTMR)
    );

    initial clkTMR = 1'b0;
    always #10 clkTMR = ~clkTMR;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, tag, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic en, input logic v, input logic [11:0] b, input logic clr,
                        input logic [1:0] st, input logic mis, input logic [3:0] err,
                        input logic [11:0] ex);
        @(negedge clkTMR);
        enTMR        = en;
        bcidValidTMR = v;
        bcidInTMR    = b;
        clrErrTMR    = clr;
        sb.push_back('{st, mis, err, ex, stepNo});
        stepNo++;
    endtask

    task automatic check_reset_values(input int tag);
        check("rst_expected", tag, 32'(expectedTMR), 32'd0);
        check("rst_state",    tag, 32'(stateTMR),    32'(S));
        check("rst_locked",   tag, 32'(lockedTMR),   32'd0);
        check("rst_mismatch", tag, 32'(mismatchTMR), 32'd0);
        check("rst_errcount", tag, 32'(errCountTMR), 32'd0);
    endtask

    // Monitor: compare the oldest queued expectation shortly after every active edge.
    always @(posedge clkTMR) begin
        #2;
        if (sb.size() > 0) begin
            monE = sb.pop_front();
            check("state",    monE.tag, 32'(stateTMR),    32'(monE.st));
            check("locked",   monE.tag, 32'(lockedTMR),   32'(monE.st == L));
            check("mismatch", monE.tag, 32'(mismatchTMR), 32'(monE.mis));
            check("errcount", monE.tag, 32'(errCountTMR), 32'(monE.err));
            check("expected", monE.tag, 32'(expectedTMR), 32'(monE.ex));
        end
    end

    initial begin
        int          nMis;
        logic [3:0]  errSat;
        logic [11:0] e;

        resetTMR     = 1'b0;
        enTMR        = 1'b0;
        bcidValidTMR = 1'b0;
        bcidInTMR    = '0;
        clrErrTMR    = 1'b0;
        #5;
        check_reset_values(-1);
        repeat (2) @(posedge clkTMR);
        @(negedge clkTMR);
        resetTMR = 1'b1;

        // Acquire from seed 100
        step(1, 1, 12'd100, 0, V, 0, 0, 12'd101);
        step(1, 1, 12'd101, 0, V, 0, 0, 12'd102);
        step(1, 1, 12'd102, 0, V, 0, 0, 12'd103);
        step(1, 1, 12'd103, 0, V, 0, 0, 12'd104);
        step(1, 1, 12'd104, 0, L, 0, 0, 12'd105);
        step(1, 0, 12'd0,   0, L, 0, 0, 12'd106);

        // Loss of lock after three consecutive wrong samples
        step(1, 1, 12'd5,   0, L, 1, 1, 12'd107);
        step(1, 1, 12'd5,   0, L, 1, 2, 12'd108);
        step(1, 1, 12'd5,   0, S, 1, 3, 12'd109);

        // Out-of-range in SEARCH is ignored; in VERIFY it pulses and drops to SEARCH
        step(1, 1, 12'd4000, 0, S, 0, 3, 12'd110);
        step(1, 1, 12'd200,  0, V, 0, 3, 12'd201);
        step(1, 1, 12'd4000, 0, S, 1, 3, 12'd202);

        // Lock across the wrap point
        step(1, 1, 12'd3561, 0, V, 0, 3, 12'd3562);
        step(1, 1, 12'd3562, 0, V, 0, 3, 12'd3563);
        step(1, 1, 12'd3563, 0, V, 0, 3, 12'd0);
        step(1, 1, 12'd0,    0, V, 0, 3, 12'd1);
        step(1, 1, 12'd1,    0, L, 0, 3, 12'd2);

        // A single wrong sample followed by a match keeps the lock
        step(1, 1, 12'd9, 0, L, 1, 4, 12'd3);
        step(1, 1, 12'd3, 0, L, 0, 4, 12'd4);

        // Disabled: predictor frozen, samples ignored
        for (int i = 0; i < 10; i++) step(0, 1, 12'd999, 0, L, 0, 4, 12'd4);
        step(1, 1, 12'd4, 0, L, 0, 4, 12'd5);

        // Saturation: pairs of mismatches separated by a match keep the lock
        nMis = 4;
        e    = 12'd5;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (j < 2) begin
                    nMis++;
                    errSat = (nMis > 15) ? 4'd15 : 4'(nMis);
                    step(1, 1, 12'd3000, 0, L, 1, errSat, e + 12'd1);
                end else begin
                    step(1, 1, e, 0, L, 0, errSat, e + 12'd1);
                end
                e = e + 12'd1;
            end
        end

        // Clear beats a same-cycle mismatch, and works while disabled
        step(1, 1, 12'd3000, 1, L, 1, 0, 12'd36);
        step(1, 1, 12'd36,   0, L, 0, 0, 12'd37);
        step(1, 1, 12'd3000, 0, L, 1, 1, 12'd38);
        step(1, 1, 12'd38,   0, L, 0, 1, 12'd39);
        step(0, 0, 12'd0,    1, L, 0, 0, 12'd39);
        step(1, 0, 12'd0,    0, L, 0, 0, 12'd40);

        // Asynchronous reset mid-lock takes effect before the next edge
        @(negedge clkTMR);
        check("pre_reset_locked", -2, 32'(lockedTMR), 32'd1);
        #3;
        resetTMR  = 1'b0;
        enTMR     = 1'b0;
        clrErrTMR = 1'b0;
        #1;
        check_reset_values(-2);
        check("sb_empty_at_reset", -2, 32'(sb.size()), 32'd0);
        @(negedge clkTMR);
        resetTMR = 1'b1;

        // In-range mismatch in VERIFY reloads the predictor
        step(1, 1, 12'd50, 0, V, 0, 0, 12'd51);
        step(1, 1, 12'd60, 0, V, 1, 0, 12'd61);
        step(1, 1, 12'd61, 0, V, 0, 0, 12'd62);
        step(1, 0, 12'd0,  0, V, 0, 0, 12'd63);

        @(posedge clkTMR);
        #3;
        check("scoreboard_drained", -3, 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
